// File: rtl/text_console_writer.sv
// Terminal-style 4x16 character buffer: byte-stream writer, async read port.
// Define TEXT_CONSOLE_SCROLL_EN to scroll on last-row wrap instead of wrapping to row 0.
module text_console_writer #(
    parameter int          ROW_BITS   = 2,
    parameter int          COL_BITS   = 4,
    parameter logic [7:0]  BLANK_CHAR = 8'd32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         char_valid,
    input  logic [7:0]                   char_data,
    output logic                         char_ready,
    input  logic [ROW_BITS+COL_BITS-1:0] char_address,
    output logic [7:0]                   char_output,
    output logic [ROW_BITS+COL_BITS-1:0] cursor_addr,
    output logic                         busy
);

    localparam int AW   = ROW_BITS + COL_BITS;
    localparam int N    = 2 ** AW;
    localparam int ROWS = 2 ** ROW_BITS;
    localparam int COLS = 2 ** COL_BITS;

    localparam logic [AW-1:0]       LAST_ADDR = AW'(N - 1);
    localparam logic [COL_BITS-1:0] LAST_COL  = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW  = ROW_BITS'(ROWS - 1);
`ifdef TEXT_CONSOLE_SCROLL_EN
    localparam logic [AW-1:0]       LAST_COPY = AW'((ROWS - 1) * COLS - 1);
    localparam logic [ROW_BITS-1:0] CLR_ROW   = LAST_ROW;
`else
    localparam logic [ROW_BITS-1:0] CLR_ROW   = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
`ifdef TEXT_CONSOLE_SCROLL_EN
        S_ROW_CLR,
        S_SCROLL
`else
        S_ROW_CLR
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [7:0]          mem_q [N];

    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          adv_row;
    logic          xfer;

    assign busy        = (state_q != S_IDLE);
    assign char_ready  = !busy;
    assign cursor_addr = {row_q, col_q};
    assign char_output = mem_q[char_address];
    assign xfer        = char_valid && char_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        we      = 1'b0;
        waddr   = {row_q, col_q};
        wdata   = BLANK_CHAR;
        adv_row = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                        we    = 1'b1;
                        wdata = char_data;
                        if (col_q == LAST_COL) begin
                            col_d   = '0;
                            adv_row = 1'b1;
                        end else begin
                            col_d = col_q + COL_BITS'(1);
                        end
                    end else if (char_data == 8'h0A) begin
                        col_d   = '0;
                        adv_row = 1'b1;
                    end else if (char_data == 8'h0D) begin
                        col_d = '0;
                    end else if (char_data == 8'h08) begin
                        if (col_q != '0) begin
                            col_d = col_q - COL_BITS'(1);
                            we    = 1'b1;
                            waddr = {row_q, col_q - COL_BITS'(1)};
                        end
                    end else if (char_data == 8'h0C) begin
                        row_d   = '0;
                        col_d   = '0;
                        cnt_d   = '0;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                we    = 1'b1;
                waddr = cnt_q;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_ROW_CLR: begin
                we    = 1'b1;
                waddr = {CLR_ROW, cnt_q[COL_BITS-1:0]};
                cnt_d = cnt_q + AW'(1);
                if (cnt_q[COL_BITS-1:0] == LAST_COL) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
`ifdef TEXT_CONSOLE_SCROLL_EN
            S_SCROLL: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = mem_q[cnt_q + AW'(COLS)];
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST_COPY) begin
                    cnt_d   = '0;
                    state_d = S_ROW_CLR;
                end
            end
`endif
            default: state_d = S_CLEAR;
        endcase

        // Wrap from the last row hands off to a busy sequence.
        if (adv_row) begin
            if (row_q != LAST_ROW) begin
                row_d = row_q + ROW_BITS'(1);
            end else begin
                col_d = '0;
                cnt_d = '0;
`ifdef TEXT_CONSOLE_SCROLL_EN
                row_d   = LAST_ROW;
                state_d = S_SCROLL;
`else
                row_d   = '0;
                state_d = S_ROW_CLR;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // The array is rebuilt by CLEAR after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Character-buffer owner for the 8x16 text display: stores a 4-row x 16-column screen of character codes.
- Write side: accepts a byte stream (CPU or UART) over a valid/ready handshake and interprets it terminal-style, with cursor, control codes, wrap and clear.
- Read side: serves the text engine's 6-bit character address with the stored character code, replacing hard-coded row ROMs.

Parameters:
- ROW_BITS, 2, log2 of screen rows; ROWS = 2**ROW_BITS.
- COL_BITS, 4, log2 of screen columns; COLS = 2**COL_BITS.
- BLANK_CHAR, 8'd32, code written by clear, backspace and row clear.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- char_valid  input  1  producer has a byte on char_data.
- char_data  input  8  byte to interpret.
- char_ready  output  1  block can accept a byte this cycle.
- char_address  input  ROW_BITS+COL_BITS  read address from the text engine, {row, col}.
- char_output  output  8  character code at char_address; combinational read.
- cursor_addr  output  ROW_BITS+COL_BITS  current cursor {row, col}.
- busy  output  1  internal clear/scroll sequence running.

Behaviour:
- Storage: ROWS*COLS x 8 array (64 bytes at defaults).
  - Address = {row, col}.
  - char_output = mem[char_address], asynchronous read, valid in every state including busy (shows in-progress content).
- Reset (rst_n low, asynchronous):
  - Outputs: cursor_addr=0, char_ready=0, busy=1.
  - State forced to CLEAR with clear counter 0. Array contents are not reset asynchronously.
- Transfer occurs when char_valid && char_ready. char_ready = (state==IDLE), a registered state decode independent of char_valid.
- States:
  - IDLE
  - CLEAR: writes BLANK_CHAR to one location per cycle, 0..ROWS*COLS-1 (64 cycles), then goes to IDLE with cursor=0.
  - ROW_CLR: writes BLANK_CHAR to 16 locations of the target row, one per cycle, then goes to IDLE.
  - SCROLL: present only with SCROLL_EN.
- Byte interpretation in IDLE, on transfer:
  - 0x20-0x7E: mem[cursor] <= char_data on the same edge. Visible on char_output the next cycle (1-cycle latency). Cursor then advances: col+1; if col==COLS-1, col=0 and row+1 (row advance, see below).
  - 0x0A (LF): col=0, row advance.
  - 0x0D (CR): col=0, row unchanged.
  - 0x08 (BS): if col>0, col-1 and mem[{row,col-1}] <= BLANK_CHAR. If col==0, no change.
  - 0x0C (FF): cursor=0, enter CLEAR (64 busy cycles).
  - Any other code: accepted and discarded, no state change.
- Row advance:
  - If row<ROWS-1: row+1, stay IDLE; char_ready remains 1 (back-to-back transfers at 1 byte/cycle).
  - If row==ROWS-1 (wrap): see Optional Feature. char_ready drops the cycle after the wrapping transfer.
- busy = (state != IDLE); char_ready = !busy.
- Reset mid-sequence: aborts immediately. The restart re-runs the full CLEAR; the partially written array is not preserved.
- char_valid held high while busy: the byte stays pending and is accepted on the first IDLE cycle. No data loss, no duplicate.

Optional Feature:
- Macro: TEXT_CONSOLE_SCROLL_EN.
- Defined: a wrap from the last row enters SCROLL.
  - mem[i] <= mem[i+COLS] for i = 0..(ROWS-1)*COLS-1, one per cycle (48 cycles).
  - Then ROW_CLR of row ROWS-1 (16 cycles); 64 busy cycles total.
  - Cursor = {ROWS-1, 0}.
- Undefined: a wrap sets cursor={0,0} and enters ROW_CLR of row 0 (16 busy cycles). Other rows are untouched.
- SCROLL state and copy counter are absent from the netlist when undefined.

Test Plan:
- Reset, then hold char_valid low:
  - busy=1 and char_ready=0 for exactly 64 cycles, then char_ready=1.
  - All 64 addresses read 0x20; cursor_addr=0.
- Send "A" (0x41) then "B" back-to-back:
  - Accepted on consecutive cycles.
  - char_output at address 0 = 0x41 one cycle after the first transfer, address 1 = 0x42.
  - cursor_addr=2.
- Send 16 x 0x58:
  - Cursor goes from {0,15} to {1,0}.
  - Then 0x08 -> no change (col 0).
  - Then 0x59, 0x08 -> addr 16 = 0x20, cursor {1,0}.
- Send 0x0A four times from cursor 0:
  - Without macro: on the fourth, cursor={0,0}, busy for 16 cycles, row 0 = 0x20.
  - With macro: busy for 64 cycles, row 0 holds old row 1 content, row 3 blank, cursor {3,0}.
- Write "HI", send 0x0C:
  - 64 busy cycles, addresses 0-1 read 0x20, cursor 0.
  - 0x07 and 0x7F are accepted with no array or cursor change.
- Pulse rst_n low for one cycle midway through a CLEAR:
  - Outputs return to reset values asynchronously.
  - A new full 64-cycle CLEAR runs before char_ready=1.
